// File: rtl/max_pool_stream.sv
// rtl/max_pool_stream.sv - streaming multi-channel signed max pool, stride POOL
// A window closes after POOL accepted beats or on last_i; its per-lane max is held in a registered output slot.
module max_pool_stream #(
  parameter int BW       = 8,
  parameter int CHANNELS = 8,
  parameter int POOL     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [CHANNELS*BW-1:0] data_i,
  input  logic                   valid_i,
  input  logic                   last_i,
  output logic                   ready_o,
  output logic [CHANNELS*BW-1:0] data_o,
  output logic                   valid_o,
  output logic                   last_o,
  input  logic                   ready_i
);

  localparam int CW = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int DW = CHANNELS * BW;
  localparam logic [CW-1:0] CNT_LAST = CW'(POOL - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic [DW-1:0] cand;
  logic          acc_in, xfer, close;

  // ready depends only on the output slot, never on valid_i
  assign ready_o = !valid_q || ready_i;
  assign acc_in  = valid_i && ready_o;
  assign xfer    = valid_q && ready_i;
  assign close   = acc_in && ((cnt_q == CNT_LAST) || last_i);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic signed [BW-1:0] in_s, acc_s;
    assign in_s = data_i[c*BW +: BW];
    assign acc_s = acc_q[c*BW +: BW];
    // the first beat of a window ignores whatever the accumulator still holds
    assign cand[c*BW +: BW] = ((cnt_q == '0) || (in_s > acc_s)) ? in_s : acc_s;
  end

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (xfer) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    if (acc_in) begin
      if (close) begin
        data_d  = cand;
        valid_d = 1'b1;
        last_d  = last_i;
        cnt_d   = '0;
      end else begin
        acc_d = cand;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;

endmodule
